// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM state encoding,
// instruction class, CSR addresses, cause codes, mstatus/mie bit positions and
// the helpers that compute the mstatus value written on trap entry/exit.
package trap_pkg;

    typedef enum logic [3:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        R_MST,
        W_MST,
        R_MTVEC,
        R_MEPC,
        CHK_MST,
        CHK_MIE,
        REDIR
    } trap_state_e;

    // Class of the sequence in flight, latched when the instruction is accepted
    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_ECALL,
        CLS_IRQ,
        CLS_MRET
    } trap_cls_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;

    localparam int MST_MIE    = 3;
    localparam int MST_MPIE   = 7;
    localparam int MST_MPP_LO = 11;
    localparam int MST_MPP_HI = 12;
    localparam int MIE_MTIE   = 7;

    // Trap entry: stash the interrupt enable in MPIE, disable interrupts, MPP = M
    function automatic logic [63:0] mstatus_on_trap(input logic [63:0] old_mst);
        logic [63:0] v;
        v                         = old_mst;
        v[MST_MPIE]               = old_mst[MST_MIE];
        v[MST_MIE]                = 1'b0;
        v[MST_MPP_HI:MST_MPP_LO]  = 2'b11;
        return v;
    endfunction

    // Trap return: restore the interrupt enable from MPIE and set MPIE again
    function automatic logic [63:0] mstatus_on_mret(input logic [63:0] old_mst);
        logic [63:0] v;
        v           = old_mst;
        v[MST_MIE]  = old_mst[MST_MPIE];
        v[MST_MPIE] = 1'b1;
        return v;
    endfunction

    // mcause value for a trap of the given class
    function automatic logic [63:0] cause_for(input trap_cls_e cls);
        return (cls == CLS_IRQ) ? CAUSE_MTI : CAUSE_ECALL_M;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of everything the trap controller exchanges with the pipeline and the
// CSR file. The controller sits on the slave side; the pipeline/CSR file (or a
// testbench) drives the master side.
interface trap_ctrl_if;

    logic        ex_valid;
    logic        ex_ready;
    logic        ex_ecall;
    logic        ex_mret;
    logic [63:0] ex_pc;
    logic [63:0] ex_next_pc;
    logic        irq_mtip;

    logic [11:0] csr_id;
    logic        csr_re;
    logic        csr_we;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;

    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        busy;

    modport slave (
        input  ex_valid, ex_ecall, ex_mret, ex_pc, ex_next_pc, irq_mtip, csr_rdata,
        output ex_ready, csr_id, csr_re, csr_we, csr_wdata,
               redirect_valid, redirect_pc, busy
    );

    modport master (
        output ex_valid, ex_ecall, ex_mret, ex_pc, ex_next_pc, irq_mtip, csr_rdata,
        input  ex_ready, csr_id, csr_re, csr_we, csr_wdata,
               redirect_valid, redirect_pc, busy
    );

endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller. Accepts one committing instruction at a time
// and, for ecall, a taken timer interrupt or mret, walks the CSR file one
// access per cycle (mepc/mcause/mstatus/mtvec) before issuing a single-cycle
// PC redirect. CSR port and redirect outputs are registered; the CSR file
// returns read data combinationally in the cycle the read is presented, so
// read results are consumed on the edge that leaves the reading state.
module trap_ctrl
    import trap_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    trap_ctrl_if.slave   bus
);

    trap_state_e r_state;
    trap_cls_e   r_cls;
    logic [63:0] r_epc;
    logic        r_mst_mie;
    logic [63:0] r_target;

    logic        r_csr_re;
    logic        r_csr_we;
    logic [11:0] r_csr_id;
    logic [63:0] r_csr_wdata;
    logic        r_redirect_valid;
    logic [63:0] r_redirect_pc;

    logic        w_idle;
    logic        w_xfer;

    assign w_idle = (r_state == IDLE);
    assign w_xfer = bus.ex_valid & bus.ex_ready;

    // Handshake and status are plain decodes of the state; ready also drops while reset is held
    always_comb begin
        bus.ex_ready       = w_idle & rst;
        bus.busy           = ~w_idle;
        bus.csr_re         = r_csr_re;
        bus.csr_we         = r_csr_we;
        bus.csr_id         = r_csr_id;
        bus.csr_wdata      = r_csr_wdata;
        bus.redirect_valid = r_redirect_valid;
        bus.redirect_pc    = r_redirect_pc;
    end

    // Sequencer: each transition also loads the CSR/redirect outputs for the state being entered
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_cls            <= CLS_NONE;
            r_epc            <= '0;
            r_mst_mie        <= 1'b0;
            r_target         <= '0;
            r_csr_re         <= 1'b0;
            r_csr_we         <= 1'b0;
            r_csr_id         <= '0;
            r_csr_wdata      <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_csr_re         <= 1'b0;
            r_csr_we         <= 1'b0;
            r_csr_id         <= '0;
            r_csr_wdata      <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;

            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_epc <= bus.ex_next_pc;
                        if (bus.ex_mret) begin
                            r_cls    <= CLS_MRET;
                            r_state  <= R_MEPC;
                            r_csr_re <= 1'b1;
                            r_csr_id <= CSR_MEPC;
                        end else if (bus.ex_ecall) begin
                            r_cls       <= CLS_ECALL;
                            r_state     <= W_MEPC;
                            r_csr_we    <= 1'b1;
                            r_csr_id    <= CSR_MEPC;
                            r_csr_wdata <= bus.ex_pc;
                        end else if (bus.irq_mtip) begin
                            r_cls    <= CLS_IRQ;
                            r_state  <= CHK_MST;
                            r_csr_re <= 1'b1;
                            r_csr_id <= CSR_MSTATUS;
                        end
                    end
                end

                CHK_MST: begin
                    r_mst_mie <= bus.csr_rdata[MST_MIE];
                    r_state   <= CHK_MIE;
                    r_csr_re  <= 1'b1;
                    r_csr_id  <= CSR_MIE;
                end

                CHK_MIE: begin
                    if (r_mst_mie && bus.csr_rdata[MIE_MTIE]) begin
                        r_state     <= W_MEPC;
                        r_csr_we    <= 1'b1;
                        r_csr_id    <= CSR_MEPC;
                        r_csr_wdata <= r_epc;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                W_MEPC: begin
                    r_state     <= W_MCAUSE;
                    r_csr_we    <= 1'b1;
                    r_csr_id    <= CSR_MCAUSE;
                    r_csr_wdata <= cause_for(r_cls);
                end

                W_MCAUSE: begin
                    r_state  <= R_MST;
                    r_csr_re <= 1'b1;
                    r_csr_id <= CSR_MSTATUS;
                end

                R_MEPC: begin
                    r_target <= bus.csr_rdata;
                    r_state  <= R_MST;
                    r_csr_re <= 1'b1;
                    r_csr_id <= CSR_MSTATUS;
                end

                R_MST: begin
                    r_state     <= W_MST;
                    r_csr_we    <= 1'b1;
                    r_csr_id    <= CSR_MSTATUS;
                    r_csr_wdata <= (r_cls == CLS_MRET) ? mstatus_on_mret(bus.csr_rdata)
                                                       : mstatus_on_trap(bus.csr_rdata);
                end

                W_MST: begin
                    if (r_cls == CLS_MRET) begin
                        r_state          <= REDIR;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_target;
                    end else begin
                        r_state  <= R_MTVEC;
                        r_csr_re <= 1'b1;
                        r_csr_id <= CSR_MTVEC;
                    end
                end

                R_MTVEC: begin
                    r_target         <= bus.csr_rdata;
                    r_state          <= REDIR;
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= {bus.csr_rdata[63:2], 2'b00};
                end

                REDIR: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl: a tiny CSR file model answers reads
// combinationally, and each cycle of every sequence is compared against
// hand-computed CSR port and redirect values.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic rst;

    logic [63:0] csrMstatus;
    logic [63:0] csrMie;
    logic [63:0] csrMtvec;
    logic [63:0] csrMepc;

    int testsRun    = 0;
    int testsFailed = 0;

    trap_ctrl_if bus();

    trap_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // CSR file model: read data is combinational on the presented address
    always_comb begin
        bus.csr_rdata = 64'h0;
        if (bus.csr_re) begin
            case (bus.csr_id)
                12'h300: bus.csr_rdata = csrMstatus;
                12'h304: bus.csr_rdata = csrMie;
                12'h305: bus.csr_rdata = csrMtvec;
                12'h341: bus.csr_rdata = csrMepc;
                default: bus.csr_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            endcase
        end
    end

    // Single point of comparison: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive the committing-instruction inputs
    task automatic applyStimulus(input logic valid, input logic ecall, input logic mret,
                                 input logic [63:0] pc, input logic [63:0] npc, input logic irq);
        bus.ex_valid   = valid;
        bus.ex_ecall   = ecall;
        bus.ex_mret    = mret;
        bus.ex_pc      = pc;
        bus.ex_next_pc = npc;
        bus.irq_mtip   = irq;
    endtask

    // Advance one clock and settle just past the edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Compare handshake/CSR control, write data and redirect for the current cycle
    task automatic expectCycle(input string tag, input logic expBusy, input logic expRe, input logic expWe,
                               input logic [11:0] expId, input logic [63:0] expWdata,
                               input logic expRv, input logic [63:0] expRpc);
        logic [16:0] obsCtrl;
        logic [16:0] expCtrl;
        obsCtrl = {bus.busy, bus.ex_ready, bus.csr_re, bus.csr_we, bus.redirect_valid, bus.csr_id};
        expCtrl = {expBusy, (!expBusy && rst), expRe, expWe, expRv, expId};
        checkOutput({tag, ".ctrl"}, 64'(obsCtrl), 64'(expCtrl));
        checkOutput({tag, ".wdata"}, bus.csr_wdata, expWdata);
        checkOutput({tag, ".rpc"}, bus.redirect_pc, expRpc);
    endtask

    initial begin
        rst        = 1'b0;
        csrMstatus = 64'h1808;
        csrMie     = 64'h0;
        csrMtvec   = 64'h8000_1003;
        csrMepc    = 64'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);

        // Reset held: idle, nothing driven, not ready
        nextCycle();
        nextCycle();
        expectCycle("rst_hold", 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);
        rst = 1'b1;
        #1;
        expectCycle("rst_release", 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);

        // ecall trap; inputs scrambled after acceptance must not leak in
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h8000_0010, 64'h8000_0014, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0);
        expectCycle("ecall.mepc",   1'b1, 1'b0, 1'b1, 12'h341, 64'h8000_0010, 1'b0, 64'h0);
        nextCycle();
        expectCycle("ecall.mcause", 1'b1, 1'b0, 1'b1, 12'h342, 64'd11, 1'b0, 64'h0);
        nextCycle();
        expectCycle("ecall.rmst",   1'b1, 1'b1, 1'b0, 12'h300, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("ecall.wmst",   1'b1, 1'b0, 1'b1, 12'h300, 64'h1880, 1'b0, 64'h0);
        nextCycle();
        expectCycle("ecall.mtvec",  1'b1, 1'b1, 1'b0, 12'h305, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("ecall.redir",  1'b1, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 64'h8000_1000);
        nextCycle();
        expectCycle("ecall.idle",   1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);

        // mret, with ecall also set (mret must win)
        csrMepc    = 64'h8000_0014;
        csrMstatus = 64'h1880;
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h8000_0100, 64'h8000_0104, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        expectCycle("mret.rmepc", 1'b1, 1'b1, 1'b0, 12'h341, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("mret.rmst",  1'b1, 1'b1, 1'b0, 12'h300, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("mret.wmst",  1'b1, 1'b0, 1'b1, 12'h300, 64'h1888, 1'b0, 64'h0);
        nextCycle();
        expectCycle("mret.redir", 1'b1, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 64'h8000_0014);
        nextCycle();
        expectCycle("mret.idle",  1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);

        // Taken timer interrupt on a plain instruction; irq drops right after acceptance
        csrMstatus = 64'h1808;
        csrMie     = 64'h80;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_001C, 64'h8000_0020, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        expectCycle("irq.chkmst", 1'b1, 1'b1, 1'b0, 12'h300, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("irq.chkmie", 1'b1, 1'b1, 1'b0, 12'h304, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("irq.mepc",   1'b1, 1'b0, 1'b1, 12'h341, 64'h8000_0020, 1'b0, 64'h0);
        nextCycle();
        expectCycle("irq.mcause", 1'b1, 1'b0, 1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b0, 64'h0);
        nextCycle();
        expectCycle("irq.rmst",   1'b1, 1'b1, 1'b0, 12'h300, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("irq.wmst",   1'b1, 1'b0, 1'b1, 12'h300, 64'h1880, 1'b0, 64'h0);
        nextCycle();
        expectCycle("irq.mtvec",  1'b1, 1'b1, 1'b0, 12'h305, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("irq.redir",  1'b1, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 64'h8000_1000);
        nextCycle();
        expectCycle("irq.idle",   1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);

        // Interrupt pending but masked in mie
        csrMie = 64'h0;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0030, 64'h8000_0034, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        expectCycle("mskmie.chkmst", 1'b1, 1'b1, 1'b0, 12'h300, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("mskmie.chkmie", 1'b1, 1'b1, 1'b0, 12'h304, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("mskmie.idle",   1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);

        // Interrupt pending but globally disabled in mstatus
        csrMstatus = 64'h1800;
        csrMie     = 64'h80;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0030, 64'h8000_0034, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        expectCycle("mskmst.chkmst", 1'b1, 1'b1, 1'b0, 12'h300, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("mskmst.chkmie", 1'b1, 1'b1, 1'b0, 12'h304, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("mskmst.idle",   1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);

        // Plain instruction without interrupt: accepted and stays idle
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0040, 64'h8000_0044, 1'b0);
        nextCycle();
        expectCycle("plain.c1", 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        nextCycle();
        expectCycle("plain.c2", 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);

        // ecall with irq pending, valid held high, reset hits while in W_MST
        csrMstatus = 64'h1808;
        csrMie     = 64'h80;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h8000_0050, 64'h8000_0054, 1'b1);
        nextCycle();
        expectCycle("ecirq.mepc",   1'b1, 1'b0, 1'b1, 12'h341, 64'h8000_0050, 1'b0, 64'h0);
        nextCycle();
        expectCycle("ecirq.mcause", 1'b1, 1'b0, 1'b1, 12'h342, 64'd11, 1'b0, 64'h0);
        nextCycle();
        expectCycle("ecirq.rmst",   1'b1, 1'b1, 1'b0, 12'h300, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("ecirq.wmst",   1'b1, 1'b0, 1'b1, 12'h300, 64'h1880, 1'b0, 64'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        nextCycle();
        expectCycle("midrst.held", 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);
        rst = 1'b1;
        #1;
        expectCycle("midrst.rel", 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("midrst.quiet", 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);

        // Deferred interrupt is seen on the following transfer
        csrMie = 64'h0;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0060, 64'h8000_0064, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        expectCycle("defer.chkmst", 1'b1, 1'b1, 1'b0, 12'h300, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("defer.chkmie", 1'b1, 1'b1, 1'b0, 12'h304, 64'h0, 1'b0, 64'h0);
        nextCycle();
        expectCycle("defer.idle",   1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 64'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
